// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA framebuffer arbiter.
//   owner_t         : which user the RAM read issued last cycle belongs to
//   DEF_*           : default screen and framebuffer dimensions
//   addr_bits()     : number of address bits needed for a given word count
package vga_fb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_DISP    = 2'd1,
    OWN_REQ     = 2'd2,
    OWN_REQ_ERR = 2'd3
  } owner_t;

  localparam int DEF_ACTIVE_COLS = 640;
  localparam int DEF_ACTIVE_ROWS = 480;
  localparam int DEF_SCALE_SHIFT = 2;
  localparam int DEF_FB_COLS     = DEF_ACTIVE_COLS >> DEF_SCALE_SHIFT;
  localparam int DEF_FB_ROWS     = DEF_ACTIVE_ROWS >> DEF_SCALE_SHIFT;

  // Smallest width (at least 1) whose range covers words-1.
  function automatic int addr_bits(input int words);
    int bits;
    bits = 1;
    while ((1 << bits) < words) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/vga_count_delay.sv
// STAGES-deep register delay line for the VGA column/row count pair, used to
// line the counts up with the pixel coming back from the framebuffer.
//   clk, rst_n : clock, asynchronous active-low reset (counts clear to 0)
//   col, row   : counts from the VGA counter
//   col_d, row_d : the same counts delayed by STAGES cycles
module vga_count_delay #(
  parameter int STAGES  = 2,
  parameter int COUNT_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COUNT_W-1:0] col,
  input  logic [COUNT_W-1:0] row,
  output logic [COUNT_W-1:0] col_d,
  output logic [COUNT_W-1:0] row_d
);

  logic [COUNT_W-1:0] col_pipe [STAGES];
  logic [COUNT_W-1:0] row_pipe [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        col_pipe[i] <= '0;
        row_pipe[i] <= '0;
      end
    end else begin
      col_pipe[0] <= col;
      row_pipe[0] <= row;
      for (int i = 1; i < STAGES; i++) begin
        col_pipe[i] <= col_pipe[i-1];
        row_pipe[i] <= row_pipe[i-1];
      end
    end
  end

  assign col_d = col_pipe[STAGES-1];
  assign row_d = row_pipe[STAGES-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbiter sharing one single-port framebuffer RAM (1-cycle read latency)
// between VGA scan-out and a generic valid/ready requester.
//   i_Clk, i_Rst_L          : pixel clock, asynchronous active-low reset
//   i_Col_Count/i_Row_Count : VGA counter position
//   i_Req_*/o_Req_Ready     : requester read/write handshake
//   o_Rsp_Valid/o_Rsp_Data  : read response, two cycles after acceptance
//   o_Req_Err               : pulse one cycle after an out-of-range request
//   o_Mem_*/i_Mem_Rdata     : framebuffer RAM port
//   o_Pixel, o_*_Count_D    : pixel plus counts delayed to match it
// Scan-out owns every cycle whose column is a multiple of the scale factor
// inside the visible area; the requester gets every other cycle.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int FB_COLS     = DEF_FB_COLS,
  parameter int FB_ROWS     = DEF_FB_ROWS,
  parameter int DATA_WIDTH  = 3,
  parameter int ADDR_WIDTH  = addr_bits(DEF_FB_COLS * DEF_FB_ROWS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [9:0]            i_Col_Count,
  input  logic [9:0]            i_Row_Count,
  input  logic                  i_Req_Valid,
  output logic                  o_Req_Ready,
  input  logic                  i_Req_We,
  input  logic [ADDR_WIDTH-1:0] i_Req_Addr,
  input  logic [DATA_WIDTH-1:0] i_Req_Wdata,
  output logic                  o_Rsp_Valid,
  output logic [DATA_WIDTH-1:0] o_Rsp_Data,
  output logic                  o_Req_Err,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic                  o_Mem_We,
  output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
  input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
  output logic [DATA_WIDTH-1:0] o_Pixel,
  output logic [9:0]            o_Col_Count_D,
  output logic [9:0]            o_Row_Count_D
);

  localparam logic [9:0]            ACT_COLS_C = 10'(ACTIVE_COLS);
  localparam logic [9:0]            ACT_ROWS_C = 10'(ACTIVE_ROWS);
  localparam logic [ADDR_WIDTH-1:0] FB_COLS_C  = ADDR_WIDTH'(FB_COLS);
  localparam logic [ADDR_WIDTH-1:0] FB_WORDS_C = ADDR_WIDTH'(FB_COLS * FB_ROWS);

  logic                  active_p0;
  logic                  slot_p0;
  logic                  accept_p0;
  logic                  oob_p0;
  logic [ADDR_WIDTH-1:0] fb_row_p0;
  logic [ADDR_WIDTH-1:0] fb_col_p0;
  logic [ADDR_WIDTH-1:0] fetch_addr_p0;
  logic [ADDR_WIDTH-1:0] mem_addr_p0;
  logic                  mem_we_p0;
  logic [ADDR_WIDTH-1:0] addr_q;
  owner_t                owner_q;
  owner_t                owner_nxt;
  logic                  err_vld_p1;
  logic [DATA_WIDTH-1:0] pix_hold_p1;
  logic                  rsp_vld_p2;
  logic [DATA_WIDTH-1:0] rsp_data_p2;
  logic [9:0]            col_p2;
  logic [9:0]            row_p2;
  logic                  active_p2;

  // ---- Stage p0: slot decode, grant, RAM drive ----
  assign active_p0 = (i_Col_Count < ACT_COLS_C) && (i_Row_Count < ACT_ROWS_C);
  assign slot_p0   = active_p0 && (i_Col_Count[SCALE_SHIFT-1:0] == '0);
  // Ready depends only on the counts so the requester can never create a
  // combinational loop through valid.
  assign o_Req_Ready = !slot_p0;
  assign accept_p0   = i_Req_Valid && !slot_p0;
  assign oob_p0      = (i_Req_Addr >= FB_WORDS_C);

  assign fb_row_p0     = ADDR_WIDTH'(i_Row_Count >> SCALE_SHIFT);
  assign fb_col_p0     = ADDR_WIDTH'(i_Col_Count >> SCALE_SHIFT);
  assign fetch_addr_p0 = fb_row_p0 * FB_COLS_C + fb_col_p0;

  always_comb begin
    owner_nxt   = OWN_NONE;
    mem_addr_p0 = addr_q;
    mem_we_p0   = 1'b0;
    if (slot_p0) begin
      mem_addr_p0 = fetch_addr_p0;
      owner_nxt   = OWN_DISP;
    end else if (accept_p0) begin
      mem_addr_p0 = i_Req_Addr;
      mem_we_p0   = i_Req_We && !oob_p0;
      if (!i_Req_We) begin
        owner_nxt = oob_p0 ? OWN_REQ_ERR : OWN_REQ;
      end
    end
  end

  assign o_Mem_Addr  = mem_addr_p0;
  assign o_Mem_We    = mem_we_p0;
  assign o_Mem_Wdata = i_Req_Wdata;

  // Idle cycles leave the RAM address where it was.
  always_ff @(posedge i_Clk) begin
    addr_q <= mem_addr_p0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_nxt;
    end
  end

  // ---- Stage p1: route returning RAM data by last cycle's owner ----
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      err_vld_p1  <= 1'b0;
      pix_hold_p1 <= '0;
      rsp_vld_p2  <= 1'b0;
      rsp_data_p2 <= '0;
    end else begin
      err_vld_p1 <= accept_p0 && oob_p0;
      rsp_vld_p2 <= (owner_q == OWN_REQ) || (owner_q == OWN_REQ_ERR);
      if (owner_q == OWN_DISP) begin
        pix_hold_p1 <= i_Mem_Rdata;
      end
      if (owner_q == OWN_REQ) begin
        rsp_data_p2 <= i_Mem_Rdata;
      end else if (owner_q == OWN_REQ_ERR) begin
        rsp_data_p2 <= '0;
      end
    end
  end

  assign o_Req_Err   = err_vld_p1;
  assign o_Rsp_Valid = rsp_vld_p2;
  assign o_Rsp_Data  = rsp_data_p2;

  // ---- Stage p2: counts aligned with the held pixel ----
  vga_count_delay #(
    .STAGES  (2),
    .COUNT_W (10)
  ) u_count_delay (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .col   (i_Col_Count),
    .row   (i_Row_Count),
    .col_d (col_p2),
    .row_d (row_p2)
  );

  assign active_p2     = (col_p2 < ACT_COLS_C) && (row_p2 < ACT_ROWS_C);
  assign o_Pixel       = active_p2 ? pix_hold_p1 : '0;
  assign o_Col_Count_D = col_p2;
  assign o_Row_Count_D = row_p2;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  col, row;
  logic        req_valid, req_ready, req_we;
  logic [14:0] req_addr;
  logic [2:0]  req_wdata;
  logic        rsp_valid, req_err;
  logic [2:0]  rsp_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata, mem_rdata;
  logic [2:0]  pixel;
  logic [9:0]  col_d, row_d;

  int checks = 0;
  int failures = 0;

  logic [2:0] ram [0:32767];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  vga_fb_arbiter dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Col_Count   (col),
    .i_Row_Count   (row),
    .i_Req_Valid   (req_valid),
    .o_Req_Ready   (req_ready),
    .i_Req_We      (req_we),
    .i_Req_Addr    (req_addr),
    .i_Req_Wdata   (req_wdata),
    .o_Rsp_Valid   (rsp_valid),
    .o_Rsp_Data    (rsp_data),
    .o_Req_Err     (req_err),
    .o_Mem_Addr    (mem_addr),
    .o_Mem_We      (mem_we),
    .o_Mem_Wdata   (mem_wdata),
    .i_Mem_Rdata   (mem_rdata),
    .o_Pixel       (pixel),
    .o_Col_Count_D (col_d),
    .o_Row_Count_D (row_d)
  );

  typedef struct {
    logic [9:0]  col;
    logic [9:0]  row;
    logic        valid;
    logic        we;
    logic [14:0] addr;
    logic [2:0]  wdata;
    logic        exp_ready;
    logic        exp_we;
    logic        chk_addr;
    logic [14:0] exp_addr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [14:0] a, input logic [2:0] d);
    req_valid = v;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic wr(input logic [14:0] a, input logic [2:0] d);
    col = 10'd700;
    row = 10'd0;
    set_req(1'b1, 1'b1, a, d);
    @(negedge clk);
    chk("preload_we", mem_we, 1);
    next_cycle();
    set_req(1'b0, 1'b0, '0, '0);
  endtask

  task automatic rd_check(input string name, input logic [14:0] a, input logic [2:0] e);
    col = 10'd700;
    row = 10'd0;
    set_req(1'b1, 1'b0, a, '0);
    next_cycle();
    set_req(1'b0, 1'b0, '0, '0);
    next_cycle();
    @(negedge clk);
    chk({name, "_vld"}, rsp_valid, 1);
    chk({name, "_data"}, rsp_data, e);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    col = 10'd700;
    row = 10'd0;
    set_req(1'b0, 1'b0, '0, '0);

    // Reset state
    #12;
    chk("rst_pixel", pixel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", req_err, 0);
    chk("rst_col_d", col_d, 0);
    chk("rst_row_d", row_d, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Preload framebuffer contents through the requester port in blanking
    wr(15'd162, 3'd5);
    wr(15'd163, 3'd2);
    wr(15'd0, 3'd1);
    wr(15'd1, 3'd2);
    wr(15'd2, 3'd3);
    wr(15'd3, 3'd4);
    wr(15'd159, 3'd6);

    // Single-cycle grant/address vectors
    vecs[0]  = '{10'd8,   10'd4,   1'b0, 1'b0, 15'd0,     3'd0, 1'b0, 1'b0, 1'b1, 15'd162};
    vecs[1]  = '{10'd0,   10'd0,   1'b1, 1'b1, 15'd9,     3'd1, 1'b0, 1'b0, 1'b1, 15'd0};
    vecs[2]  = '{10'd639, 10'd0,   1'b1, 1'b1, 15'd5,     3'd6, 1'b1, 1'b1, 1'b1, 15'd5};
    vecs[3]  = '{10'd700, 10'd10,  1'b1, 1'b1, 15'd19200, 3'd7, 1'b1, 1'b0, 1'b1, 15'd19200};
    vecs[4]  = '{10'd4,   10'd479, 1'b1, 1'b1, 15'd7,     3'd1, 1'b0, 1'b0, 1'b1, 15'd19041};
    vecs[5]  = '{10'd5,   10'd479, 1'b1, 1'b1, 15'd7,     3'd1, 1'b1, 1'b1, 1'b1, 15'd7};
    vecs[6]  = '{10'd0,   10'd480, 1'b0, 1'b0, 15'd0,     3'd0, 1'b1, 1'b0, 1'b0, 15'd0};
    vecs[7]  = '{10'd640, 10'd0,   1'b1, 1'b0, 15'd100,   3'd0, 1'b1, 1'b0, 1'b1, 15'd100};
    vecs[8]  = '{10'd636, 10'd0,   1'b0, 1'b0, 15'd0,     3'd0, 1'b0, 1'b0, 1'b1, 15'd159};
    vecs[9]  = '{10'd12,  10'd8,   1'b1, 1'b0, 15'd3,     3'd0, 1'b0, 1'b0, 1'b1, 15'd323};
    vecs[10] = '{10'd799, 10'd524, 1'b1, 1'b1, 15'd19199, 3'd2, 1'b1, 1'b1, 1'b1, 15'd19199};
    vecs[11] = '{10'd1,   10'd0,   1'b1, 1'b1, 15'd32767, 3'd5, 1'b1, 1'b0, 1'b1, 15'd32767};

    for (int i = 0; i < 12; i++) begin
      col = vecs[i].col;
      row = vecs[i].row;
      set_req(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
      chk($sformatf("vec%0d_we", i), mem_we, vecs[i].exp_we);
      if (vecs[i].chk_addr) chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
      next_cycle();
    end
    set_req(1'b0, 1'b0, '0, '0);
    col = 10'd700;
    row = 10'd0;
    next_cycle();
    next_cycle();

    // Display fetch: row 4 col 8 -> word 162, pixel held for 4 cycles
    for (int i = 0; i < 7; i++) begin
      col = 10'(8 + i);
      row = 10'd4;
      @(negedge clk);
      if (i == 0) begin
        chk("fetch_addr", mem_addr, 162);
        chk("fetch_we", mem_we, 0);
      end
      if (i >= 2) begin
        chk($sformatf("fetch_pix%0d", i), pixel, (i <= 5) ? 5 : 2);
        chk($sformatf("fetch_col_d%0d", i), col_d, 8 + i - 2);
        chk($sformatf("fetch_row_d%0d", i), row_d, 4);
      end
      next_cycle();
    end

    // Active-region write deferred by a display slot
    col = 10'd4;
    row = 10'd0;
    set_req(1'b1, 1'b1, 15'd10, 3'd3);
    @(negedge clk);
    chk("awr_ready_c4", req_ready, 0);
    chk("awr_we_c4", mem_we, 0);
    chk("awr_addr_c4", mem_addr, 1);
    next_cycle();
    col = 10'd5;
    @(negedge clk);
    chk("awr_ready_c5", req_ready, 1);
    chk("awr_we_c5", mem_we, 1);
    chk("awr_addr_c5", mem_addr, 10);
    chk("awr_wdata_c5", mem_wdata, 3);
    next_cycle();
    col = 10'd6;
    set_req(1'b0, 1'b0, '0, '0);
    next_cycle();
    rd_check("awr_readback", 15'd10, 3'd3);

    // Blanking back-to-back reads
    col = 10'd700;
    row = 10'd0;
    next_cycle();
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) set_req(1'b1, 1'b0, 15'(i), '0);
      else set_req(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (i < 4) chk($sformatf("b2b_ready%0d", i), req_ready, 1);
      chk($sformatf("b2b_vld%0d", i), rsp_valid, (i >= 2 && i <= 5) ? 1 : 0);
      if (i >= 2 && i <= 5) chk($sformatf("b2b_data%0d", i), rsp_data, i - 1);
      next_cycle();
    end

    // Out-of-range write then read
    set_req(1'b1, 1'b1, 15'd19200, 3'd7);
    @(negedge clk);
    chk("oobw_ready", req_ready, 1);
    chk("oobw_we", mem_we, 0);
    chk("oobw_err_t0", req_err, 0);
    next_cycle();
    set_req(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("oobw_err_t1", req_err, 1);
    next_cycle();
    @(negedge clk);
    chk("oobw_err_t2", req_err, 0);
    next_cycle();
    set_req(1'b1, 1'b0, 15'd20000, '0);
    @(negedge clk);
    chk("oobr_we", mem_we, 0);
    next_cycle();
    set_req(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("oobr_err_t1", req_err, 1);
    chk("oobr_vld_t1", rsp_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("oobr_vld_t2", rsp_valid, 1);
    chk("oobr_data_t2", rsp_data, 0);
    next_cycle();
    @(negedge clk);
    chk("oobr_vld_t3", rsp_valid, 0);
    next_cycle();

    // Blanking output: right edge of the visible area, then below it
    for (int i = 0; i < 8; i++) begin
      col = 10'(636 + i);
      row = 10'd0;
      @(negedge clk);
      chk($sformatf("edge_ready%0d", i), req_ready, (i == 0) ? 0 : 1);
      if (i >= 2) begin
        chk($sformatf("edge_pix%0d", i), pixel, (636 + i - 2 < 640) ? 6 : 0);
        chk($sformatf("edge_col_d%0d", i), col_d, 636 + i - 2);
      end
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      col = 10'(i);
      row = 10'd480;
      @(negedge clk);
      chk($sformatf("vblank_ready%0d", i), req_ready, 1);
      if (i >= 2) begin
        chk($sformatf("vblank_pix%0d", i), pixel, 0);
        chk($sformatf("vblank_row_d%0d", i), row_d, 480);
      end
      next_cycle();
    end

    // Reset while a read is in flight
    rd_check("pre_rst_read", 15'd2, 3'd3);
    col = 10'd700;
    row = 10'd0;
    next_cycle();
    next_cycle();
    set_req(1'b1, 1'b0, 15'd0, '0);
    next_cycle();
    set_req(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    chk("mrst_pixel", pixel, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_rsp_data", rsp_data, 0);
    chk("mrst_err", req_err, 0);
    chk("mrst_col_d", col_d, 0);
    chk("mrst_row_d", row_d, 0);
    @(negedge clk);
    chk("mrst_vld_hold", rsp_valid, 0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_vld%0d", i), rsp_valid, 0);
      next_cycle();
    end
    rd_check("post_rst_read", 15'd1, 3'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
